z80_bus_bridge: RTL and testbench

//  Downstream of the Z80 core (z80_top_direct_n). Consumes its active-low bus strobes and serves each cycle.

---
 rtl/z80_bus_pkg.sv | 24 ++
 rtl/z80_strobe_decode.sv | 36 +++
 rtl/z80_bus_bridge.sv | 146 ++++++++++++++
 tb/tb_z80_bus_bridge.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus bridge and its strobe decoder.
package z80_bus_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} bridge_state_e;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_MEM_RD,
    CYC_MEM_WR,
    CYC_IO_RD,
    CYC_IO_WR
  } cyc_kind_e;

  localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;

  function automatic logic cyc_is_write(input cyc_kind_e k);
    return (k == CYC_MEM_WR) || (k == CYC_IO_WR);
  endfunction

  function automatic logic cyc_is_io(input cyc_kind_e k);
    return (k == CYC_IO_RD) || (k == CYC_IO_WR);
  endfunction

endpackage

// File: rtl/z80_strobe_decode.sv
// Combinational decode of Z80 bus strobes into a cycle kind.
// I/O decode is present only when Z80_BRIDGE_IO_EN is defined.
module z80_strobe_decode
  import z80_bus_pkg::*;
(
  input  logic      nM1,
  input  logic      nMREQ,
  input  logic      nIORQ,
  input  logic      nRD,
  input  logic      nWR,
  input  logic      nRFSH,
  output cyc_kind_e kind
);

  logic rw_act;
  assign rw_act = !nRD || !nWR;

`ifndef Z80_BRIDGE_IO_EN
  logic unused_io;
  assign unused_io = nM1 & nIORQ;
`endif

  // nWR wins when both strobes are low, so a glitchy RD+WR overlap is a write.
  always_comb begin
    kind = CYC_NONE;
    if (!nMREQ && nRFSH && rw_act) begin
      kind = !nWR ? CYC_MEM_WR : CYC_MEM_RD;
    end
`ifdef Z80_BRIDGE_IO_EN
    else if (!nIORQ && nM1 && rw_act) begin
      kind = !nWR ? CYC_IO_WR : CYC_IO_RD;
    end
`endif
  end

endmodule

// File: rtl/z80_bus_bridge.sv
// Bridges Z80 MREQ (and IORQ with Z80_BRIDGE_IO_EN) cycles onto a req/ack port,
// stretching the core with nWAIT and aborting to open-bus data after TIMEOUT_CYC.
module z80_bus_bridge
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              nM1,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic              nRFSH,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D_IN,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_OE,
  output logic              nWAIT,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_is_io,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

  cyc_kind_e     kind;
  bridge_state_e state_q, state_d;
  logic          req_q, req_d, we_q, we_d, io_q, io_d;
  logic          doe_q, doe_d, nwait_q, nwait_d, to_err_q, to_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d;
  logic [15:0]       cnt_q, cnt_d;

  z80_strobe_decode u_decode (
    .nM1   (nM1),
    .nMREQ (nMREQ),
    .nIORQ (nIORQ),
    .nRD   (nRD),
    .nWR   (nWR),
    .nRFSH (nRFSH),
    .kind  (kind)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    io_d     = io_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    nwait_d  = nwait_q;
    to_err_d = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (kind != CYC_NONE) begin
          addr_d  = A;
          wdata_d = D_IN;
          we_d    = cyc_is_write(kind);
          io_d    = cyc_is_io(kind);
          req_d   = 1'b1;
          nwait_d = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (req_q && mem_ack) begin
          if (!we_q) dout_d = mem_rdata;
          req_d   = 1'b0;
          state_d = HOLD;
        end else if (cnt_q + 16'd1 == TO_LIM) begin
          if (!we_q) dout_d = DATA_W'(OPEN_BUS_DATA);
          req_d    = 1'b0;
          nwait_d  = 1'b1;
          doe_d    = !we_q;
          to_err_d = 1'b1;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        // After an ack, nWAIT is held one extra cycle so the read data is settled on D.
        if (!nwait_q) begin
          nwait_d = 1'b1;
          doe_d   = !we_q;
        end else if (nRD && nWR && nMREQ && nIORQ) begin
          doe_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
      nwait_q  <= 1'b1;
      to_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      io_q     <= io_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      nwait_q  <= nwait_d;
      to_err_q <= to_err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign D_OUT       = dout_q;
  assign D_OE        = doe_q;
  assign nWAIT       = nwait_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_is_io   = io_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed plus randomized bench for z80_bus_bridge against a transaction-level model.
module tb_z80_bus_bridge;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE, nWAIT, mem_req, mem_we, mem_is_io;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        timeout_err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_dout = 8'h00;

  always #5 CLK = ~CLK;

  z80_bus_bridge #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RESET(RESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_IN(D_IN),
    .D_OUT(D_OUT), .D_OE(D_OE), .nWAIT(nWAIT), .mem_req(mem_req),
    .mem_we(mem_we), .mem_is_io(mem_is_io), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
  endtask

  // One core cycle; k = REQ cycle (1-based from mem_req rising) carrying the ack, 0 = never.
  task automatic run_cycle(input string tag, input bit io, input bit rd_n, input bit wr_n,
                           input logic [15:0] addr, input logic [7:0] din,
                           input int k, input logic [7:0] rdata);
    bit   issue, wr, by_ack, stable, prev_req, doe_seen;
    int   exp_low, exp_reqc, low, reqc, rises, toerrs;
    wr = !wr_n;
`ifdef Z80_BRIDGE_IO_EN
    issue = 1'b1;
`else
    issue = !io;
`endif
    by_ack   = (k >= 1) && (k <= TO);
    exp_low  = !issue ? 0 : (by_ack ? k + 1 : TO);
    exp_reqc = !issue ? 0 : (by_ack ? k : TO);
    if (issue && !wr) exp_dout = by_ack ? rdata : 8'hFF;
    low = 0; reqc = 0; rises = 0; toerrs = 0; stable = 1'b1; prev_req = 1'b0; doe_seen = 1'b0;

    @(posedge CLK); #1;
    A = addr; D_IN = din; nRD = rd_n; nWR = wr_n;
    if (io) nIORQ = 1'b0; else nMREQ = 1'b0;
    for (int c = 1; c <= TO + 4; c++) begin
      @(posedge CLK); #1;
      mem_ack   = (c == k);
      mem_rdata = (c == k) ? rdata : 8'($urandom);
      @(negedge CLK);
      if (!nWAIT) low++;
      if (timeout_err) toerrs++;
      if (D_OE) doe_seen = 1'b1;
      if (mem_req) begin
        reqc++;
        if (!prev_req) rises++;
        if (mem_addr !== addr || mem_we !== wr || mem_wdata !== din || mem_is_io !== io)
          stable = 1'b0;
      end
      prev_req = mem_req;
    end
    check({tag, " nwait_low"}, low, exp_low);
    check({tag, " req_cycles"}, reqc, exp_reqc);
    check({tag, " req_count"}, rises, issue ? 1 : 0);
    check({tag, " timeout_err"}, toerrs, (issue && !by_ack) ? 1 : 0);
    check({tag, " req_fields"}, stable, 1);
    check({tag, " doe_seen"}, doe_seen, issue && !wr);
    check({tag, " d_out"}, D_OUT, exp_dout);
    check({tag, " d_oe_hold"}, D_OE, issue && !wr);
    check({tag, " nwait_end"}, nWAIT, 1);

    @(posedge CLK); #1;
    mem_ack = 1'b0;
    bus_idle();
    @(negedge CLK);
    @(negedge CLK);
    check({tag, " d_oe_release"}, D_OE, 0);
    check({tag, " req_release"}, mem_req, 0);
  endtask

  // Drives a non-transaction strobe pattern and confirms the bridge stays idle.
  task automatic idle_probe(input string tag, input bit m1_n, input bit mreq_n,
                            input bit iorq_n, input bit rfsh_n, input bit ack);
    bit moved;
    moved = 1'b0;
    @(posedge CLK); #1;
    nM1 = m1_n; nMREQ = mreq_n; nIORQ = iorq_n; nRFSH = rfsh_n; nRD = 1'b0;
    mem_ack = ack; mem_rdata = 8'h77;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (mem_req || !nWAIT || D_OE || D_OUT !== exp_dout) moved = 1'b1;
    end
    check({tag, " stays_idle"}, moved, 0);
    @(posedge CLK); #1;
    bus_idle(); mem_ack = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; A = 16'h0; D_IN = 8'h0;
    bus_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst d_out", D_OUT, 0);
    check("rst d_oe", D_OE, 0);
    check("rst nwait", nWAIT, 1);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_is_io", mem_is_io, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst timeout_err", timeout_err, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    run_cycle("rd1234", 1'b0, 1'b0, 1'b1, 16'h1234, 8'h00, 3, 8'hA5);
    run_cycle("wr8000", 1'b0, 1'b1, 1'b0, 16'h8000, 8'h5A, 1, 8'h00);
    idle_probe("refresh", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_probe("inta",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_probe("stray_ack", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    run_cycle("rd_timeout", 1'b0, 1'b0, 1'b1, 16'h2222, 8'h00, 0, 8'h11);
    run_cycle("wr_timeout", 1'b0, 1'b1, 1'b0, 16'h3333, 8'h44, 0, 8'h00);
    run_cycle("ack_at_limit", 1'b0, 1'b0, 1'b1, 16'h4444, 8'h00, TO, 8'h96);
    run_cycle("ack_late", 1'b0, 1'b0, 1'b1, 16'h5555, 8'h00, TO + 1, 8'h69);
    run_cycle("io_rd42", 1'b1, 1'b0, 1'b1, 16'h0042, 8'h00, 2, 8'h3C);
    run_cycle("rd_wr_both", 1'b0, 1'b0, 1'b0, 16'h6666, 8'hC3, 2, 8'h00);

    // Reset during REQ, strobes released in the same cycle.
    @(posedge CLK); #1;
    A = 16'hABCD; nMREQ = 1'b0; nRD = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1; bus_idle();
    @(negedge CLK);
    @(negedge CLK);
    check("midrst mem_req", mem_req, 0);
    check("midrst nwait", nWAIT, 1);
    check("midrst d_oe", D_OE, 0);
    check("midrst d_out", D_OUT, 0);
    exp_dout = 8'h00;
    @(posedge CLK); #1;
    RESET = 1'b0;
    run_cycle("post_rst_rd", 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 2, 8'hE7);

    for (int i = 0; i < 40; i++) begin
      bit          io, rd_n, wr_n;
      int          sel;
      sel  = $urandom_range(0, 4);
      io   = (sel == 2) || (sel == 3);
      rd_n = !((sel == 0) || (sel == 2) || (sel == 4));
      wr_n = !((sel == 1) || (sel == 3) || (sel == 4));
      run_cycle("rand", io, rd_n, wr_n, 16'($urandom), 8'($urandom),
                $urandom_range(0, 11), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
